// File: rtl/fp_pkg.sv
// fp_pkg: shared constants, state type and packed-word layout for the
// floating-point normalize/pack datapath.
package fp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MANT_W  = 24;   // includes hidden bit
  localparam int unsigned EXP_MAX = 255;  // all-ones exponent code
  localparam int unsigned BIAS    = 127;

  // IEEE-754 single-precision field offsets
  localparam int unsigned SIGN_POS = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;
  localparam int unsigned FRAC_LSB = 0;

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;

endpackage

// File: rtl/fp_pack.sv
// fp_pack: combinational packer. Builds the 32-bit IEEE-754 word and status
// flags from the normalizer's working sign/exponent/mantissa.
//   sign_i, exp_i, mant_i      : working value
//   word_o                     : {sign, exp, frac}
//   overflow_o / underflow_o / zero_o : infinity / nonzero subnormal / signed zero
// Priority: infinity, zero, normalized, subnormal. The subnormal branch is only
// selected by the caller once the exponent has reached 1 or below.
module fp_pack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MANT_W  = 24,
  parameter int unsigned EXP_MAX = 255
) (
  input  logic                     sign_i,
  input  logic [EXP_W-1:0]         exp_i,
  input  logic [MANT_W-1:0]        mant_i,
  output logic [EXP_W+MANT_W-1:0]  word_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic                     zero_o
);

  localparam logic [EXP_W-1:0] ExpMax = EXP_W'(EXP_MAX);

  always_comb begin
    word_o           = '0;
    overflow_o       = 1'b0;
    underflow_o      = 1'b0;
    zero_o           = 1'b0;
    word_o[SIGN_POS] = sign_i;
    if (exp_i == ExpMax) begin
      word_o[EXP_MSB:EXP_LSB] = '1;
      overflow_o              = 1'b1;
    end else if (mant_i == '0) begin
      zero_o = 1'b1;
    end else if (mant_i[MANT_W-1]) begin
      word_o[EXP_MSB:EXP_LSB]   = exp_i;
      word_o[FRAC_MSB:FRAC_LSB] = mant_i[MANT_W-2:0];
    end else begin
      word_o[FRAC_MSB:FRAC_LSB] = mant_i[MANT_W-2:0];
      underflow_o               = 1'b1;
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// fp_normalize: iterative normalizer behind the 24-bit mantissa add/sub unit.
// Captures the raw sum on load, then performs one normalization action per
// enabled cycle and packs an IEEE-754 single-precision word.
//   clk, rst (async, active-high), en (clock enable), load (capture operands)
//   mant_in, carry_in, sign_in, exp_in : raw adder result
//   result  : packed word, ready : result valid
//   overflow / underflow / zero : infinity / nonzero subnormal / signed zero
// Optional build macro FP_NORMALIZE_ROUND_NEAREST_EN: the carry right-shift
// rounds to nearest-even using the shifted-out bit; otherwise it truncates.
module fp_normalize
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MANT_W  = 24,
  parameter int unsigned EXP_MAX = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load,
  input  logic [MANT_W-1:0]        mant_in,
  input  logic                     carry_in,
  input  logic                     sign_in,
  input  logic [EXP_W-1:0]         exp_in,
  output logic [EXP_W+MANT_W-1:0]  result,
  output logic                     ready,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     zero
);

  localparam logic [EXP_W-1:0] ExpMax = EXP_W'(EXP_MAX);

  state_e                    state_q, state_d;
  logic [MANT_W-1:0]         mant_q, mant_d;
  logic [EXP_W-1:0]          exp_q, exp_d;
  logic                      carry_q, carry_d;
  logic                      sign_q, sign_d;
  logic [EXP_W+MANT_W-1:0]   result_q, result_d;
  logic                      ready_q, ready_d;
  logic                      overflow_q, overflow_d;
  logic                      underflow_q, underflow_d;
  logic                      zero_q, zero_d;

  logic [EXP_W+MANT_W-1:0]   pack_word;
  logic                      pack_ovf, pack_unf, pack_zero;

  fp_pack #(
    .EXP_W   (EXP_W),
    .MANT_W  (MANT_W),
    .EXP_MAX (EXP_MAX)
  ) u_pack (
    .sign_i      (sign_q),
    .exp_i       (exp_q),
    .mant_i      (mant_q),
    .word_o      (pack_word),
    .overflow_o  (pack_ovf),
    .underflow_o (pack_unf),
    .zero_o      (pack_zero)
  );

  // Carry right-shift: shifted mantissa and bumped exponent.
  logic [MANT_W-1:0] shr_mant;
  logic [EXP_W:0]    exp_inc;  // one bit wider so +2 near the top cannot wrap
  logic [EXP_W-1:0]  shr_exp;

  always_comb begin
    shr_mant = {1'b1, mant_q[MANT_W-1:1]};
    exp_inc  = {1'b0, exp_q} + (EXP_W+1)'(1);
`ifdef FP_NORMALIZE_ROUND_NEAREST_EN
    // Guard = shifted-out bit; round up only when the kept LSB is odd.
    if (mant_q[0] && shr_mant[0]) begin
      if (&shr_mant) begin
        // Increment wraps to 2^MANT_W: renormalize in the same cycle.
        shr_mant = {1'b1, {(MANT_W-1){1'b0}}};
        exp_inc  = {1'b0, exp_q} + (EXP_W+1)'(2);
      end else begin
        shr_mant = shr_mant + MANT_W'(1);
      end
    end
`endif
    // Saturate at the all-ones code so the infinity rule fires next cycle.
    shr_exp = (exp_inc >= {1'b0, ExpMax}) ? ExpMax : exp_inc[EXP_W-1:0];
  end

  // Any condition that lets the packer produce the final word this cycle.
  logic finish;
  assign finish = (exp_q == ExpMax) ||
                  (!carry_q && ((mant_q == '0) || mant_q[MANT_W-1] ||
                                (exp_q <= EXP_W'(1))));

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    carry_d     = carry_q;
    sign_d      = sign_q;
    result_d    = result_q;
    ready_d     = ready_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    zero_d      = zero_q;

    if (load) begin
      mant_d      = mant_in;
      exp_d       = exp_in;
      carry_d     = carry_in;
      sign_d      = sign_in;
      ready_d     = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      zero_d      = 1'b0;
      state_d     = NORM;
    end else if (state_q == NORM) begin
      if (finish) begin
        result_d    = pack_word;
        overflow_d  = pack_ovf;
        underflow_d = pack_unf;
        zero_d      = pack_zero;
        ready_d     = 1'b1;
        state_d     = DONE;
      end else if (carry_q) begin
        mant_d  = shr_mant;
        exp_d   = shr_exp;
        carry_d = 1'b0;
      end else begin
        mant_d = {mant_q[MANT_W-2:0], 1'b0};
        exp_d  = exp_q - EXP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      carry_q     <= 1'b0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      carry_q     <= carry_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      ready_q     <= ready_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      zero_q      <= zero_d;
    end
  end

  assign result    = result_q;
  assign ready     = ready_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Bench for fp_normalize: directed cases plus random operands checked against
// an arithmetic reference model of the normalize/pack rules.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [23:0] mant_in = '0;
  logic        carry_in = 1'b0;
  logic        sign_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic [31:0] result;
  logic        ready, overflow, underflow, zero;

  int checks = 0;
  int errors = 0;

  fp_normalize dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .mant_in   (mant_in),
    .carry_in  (carry_in),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .result    (result),
    .ready     (ready),
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: value = (carry*2^24 + mant) * 2^(exp-bias), normalized in plain arithmetic.
  function automatic void ref_model(input bit s, input bit c, input bit [23:0] m_in,
                                    input bit [7:0] e_in, output logic [31:0] res,
                                    output logic ov, output logic un, output logic zr,
                                    output int lat);
    longint m = longint'(m_in);
    int     e = int'(e_in);
    longint v;
    res = '0; ov = 0; un = 0; zr = 0; lat = 1;
    if (e == 255) begin
      res = {s, 8'hFF, 23'd0}; ov = 1; return;
    end
    if (c) begin
      v = (longint'(1) << 24) + m;
      m = v / 2;
`ifdef FP_NORMALIZE_ROUND_NEAREST_EN
      if ((v % 2) == 1 && (m % 2) == 1) m = m + 1;
`endif
      e = e + 1;
      if (m == (longint'(1) << 24)) begin
        m = longint'(1) << 23; e = e + 1;
      end
      lat = 2;
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0}; ov = 1; return;
      end
    end
    if (m == 0) begin
      res = {s, 31'd0}; zr = 1; return;
    end
    while (m < (longint'(1) << 23) && e > 1) begin
      m = m * 2; e = e - 1; lat++;
    end
    if (m >= (longint'(1) << 23)) res = {s, 8'(e), 23'(m)};
    else begin
      res = {s, 8'd0, 23'(m)}; un = 1;
    end
  endfunction

  // Load one operand set, then count edges until ready (bounded).
  task automatic do_op(input bit s, input bit c, input bit [23:0] m, input bit [7:0] e,
                       input bit rand_en, input int hold_at, output int en_edges,
                       output int all_edges, output bit timeout);
    @(negedge clk);
    en = 1; load = 1; sign_in = s; carry_in = c; mant_in = m; exp_in = e;
    @(posedge clk);
    #1;
    load = 0;
    mant_in = 24'($urandom); exp_in = 8'($urandom); carry_in = 1'($urandom);
    sign_in = 1'($urandom);
    en_edges = 0; all_edges = 0; timeout = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hold_at > 0 && all_edges >= hold_at && all_edges < hold_at + 3) en = 0;
      else if (rand_en) en = ($urandom % 3) != 0;
      else en = 1;
      @(posedge clk);
      all_edges++;
      if (en) en_edges++;
      #1;
      if (ready) begin
        timeout = 0;
        break;
      end
    end
    en = 1;
  endtask

  task automatic check_op(input string tag, input int got_lat, input int want_lat,
                          input bit to, input logic [31:0] want_res, input logic want_ov,
                          input logic want_un, input logic want_zr);
    chk({tag, ".timeout"}, 32'(to), 32'd0);
    chk({tag, ".latency"}, 32'(got_lat), 32'(want_lat));
    chk({tag, ".result"}, result, want_res);
    chk({tag, ".ready"}, 32'(ready), 32'd1);
    chk({tag, ".overflow"}, 32'(overflow), 32'(want_ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(want_un));
    chk({tag, ".zero"}, 32'(zero), 32'(want_zr));
  endtask

  initial begin
    int          lat, all_lat, want_lat;
    bit          to;
    logic [31:0] want_res;
    logic        w_ov, w_un, w_zr;
    bit          rs, rc;
    bit [23:0]   rm;
    bit [7:0]    re;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.result", result, 32'h0);
    chk("reset.ready", 32'(ready), 32'd0);
    chk("reset.flags", {29'd0, overflow, underflow, zero}, 32'd0);
    @(negedge clk);
    rst = 0;

    // Normalized input: 3.0
    do_op(0, 0, 24'hC00000, 8'd128, 0, 0, lat, all_lat, to);
    check_op("norm", lat, 1, to, 32'h40400000, 0, 0, 0);

    // Asynchronous reset mid-normalization
    @(negedge clk);
    en = 1; load = 1; sign_in = 1; carry_in = 0; mant_in = 24'h000001; exp_in = 8'd130;
    @(negedge clk);
    load = 0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("arst.result", result, 32'h0);
    chk("arst.ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst.idle_ready", 32'(ready), 32'd0);
    chk("arst.idle_result", result, 32'h0);

    // Carry without rounding effect
    do_op(0, 1, 24'h000000, 8'd127, 0, 0, lat, all_lat, to);
    check_op("carry", lat, 2, to, 32'h40000000, 0, 0, 0);

    // Carry with guard bit set
`ifdef FP_NORMALIZE_ROUND_NEAREST_EN
    want_res = 32'h40000002;
`else
    want_res = 32'h40000001;
`endif
    do_op(0, 1, 24'h000003, 8'd127, 0, 0, lat, all_lat, to);
    check_op("carry_rnd", lat, 2, to, want_res, 0, 0, 0);

    // Longest normalization
    do_op(1, 0, 24'h000001, 8'd130, 0, 0, lat, all_lat, to);
    check_op("long", lat, 24, to, 32'hB5800000, 0, 0, 0);

    // Same with en held low for 3 cycles mid-run
    do_op(1, 0, 24'h000001, 8'd130, 0, 10, lat, all_lat, to);
    check_op("long_hold", lat, 24, to, 32'hB5800000, 0, 0, 0);
    chk("long_hold.edges", 32'(all_lat), 32'd27);

    // Subnormal
    do_op(0, 0, 24'h100000, 8'd2, 0, 0, lat, all_lat, to);
    check_op("subnorm", lat, 2, to, 32'h00200000, 0, 1, 0);

    // exp_in = 0 with unnormalized mantissa packs immediately
    do_op(0, 0, 24'h012345, 8'd0, 0, 0, lat, all_lat, to);
    check_op("subnorm_e0", lat, 1, to, 32'h00012345, 0, 1, 0);

    // Overflow via carry
    do_op(0, 1, 24'h000000, 8'd254, 0, 0, lat, all_lat, to);
    check_op("ovf", lat, 2, to, 32'h7F800000, 1, 0, 0);

    // Signed zero
    do_op(1, 0, 24'h000000, 8'd100, 0, 0, lat, all_lat, to);
    check_op("zero", lat, 1, to, 32'h80000000, 0, 0, 1);

    // Load during normalization aborts and restarts
    @(negedge clk);
    en = 1; load = 1; sign_in = 0; carry_in = 0; mant_in = 24'h000001; exp_in = 8'd130;
    @(negedge clk);
    load = 0;
    repeat (5) @(posedge clk);
    do_op(1, 0, 24'h800000, 8'd127, 0, 0, lat, all_lat, to);
    check_op("abort", lat, 1, to, 32'hBF800000, 0, 0, 0);

    // Random operands against the reference model
    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom);
      rc = ($urandom % 4) == 0;
      rm = 24'($urandom) >> $urandom_range(0, 24);
      case ($urandom % 4)
        0:       re = 8'($urandom_range(0, 3));
        1:       re = 8'($urandom_range(250, 255));
        default: re = 8'($urandom);
      endcase
      if (n == 0) begin
        rc = 1; rm = 24'hFFFFFF; re = 8'd100;
      end
      ref_model(rs, rc, rm, re, want_res, w_ov, w_un, w_zr, want_lat);
      do_op(rs, rc, rm, re, n[0], 0, lat, all_lat, to);
      check_op($sformatf("rand%0d", n), lat, want_lat, to, want_res, w_ov, w_un, w_zr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
